// File: rtl/psk_deframer_if.sv
// Byte-stream handshake between the deframer output FIFO and its downstream sink.
interface psk_deframer_if;
  logic [7:0] byte_tdata;
  logic       byte_tvalid;
  logic       byte_tlast;
  logic       byte_tready;

  modport master (
    output byte_tdata,
    output byte_tvalid,
    output byte_tlast,
    input  byte_tready
  );

  modport slave (
    input  byte_tdata,
    input  byte_tvalid,
    input  byte_tlast,
    output byte_tready
  );
endinterface

// File: rtl/psk_deframer.sv
// PSK deframer: serialises BPSK/QPSK decisions, hunts for the sync word (either
// polarity), packs the following payload into bytes and queues them in a small
// output FIFO.
module psk_deframer #(
  parameter int unsigned SYNC_LEN      = 16,
  parameter logic [31:0] SYNC_WORD     = 32'h0000_EB90,
  parameter int unsigned PAYLOAD_BYTES = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n_32M768,
  input  logic              mode,
  input  logic              BPSK,
  input  logic [1:0]        QPSK,
  input  logic              vld,
  psk_deframer_if.master    byte_if,
  output logic              locked,
  output logic              overflow
);

  localparam int unsigned          AW       = $clog2(FIFO_DEPTH);
  localparam logic [SYNC_LEN-1:0]  SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [7:0]           LAST_IDX = 8'(PAYLOAD_BYTES - 1);
  localparam logic [AW:0]          FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {ST_SEARCH, ST_PAYLOAD} state_t;

  // Framer state
  state_t              state_q, state_d;
  logic [SYNC_LEN-1:0] sync_q, sync_d;
  logic                inv_q, inv_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [7:0]          bytecnt_q, bytecnt_d;
  logic [7:0]          shr_q, shr_d;

  // Per-cycle bit processing scratch
  logic                take;
  logic                din;
  logic                stop;
  logic                push;
  logic [7:0]          push_data;
  logic                push_last;

  // FIFO state
  logic [8:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         cnt_q;
  logic                overflow_q;
  logic                pop;
  logic                accept;

  // Walk up to two bits per cycle through the search/payload machine in arrival order.
  // A frame ending on the first bit of a dibit sets stop, so the second bit is dropped.
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    inv_d     = inv_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    shr_d     = shr_q;
    take      = 1'b0;
    din       = 1'b0;
    stop      = 1'b0;
    push      = 1'b0;
    push_data = '0;
    push_last = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      take = vld && !stop && ((k == 0) || mode);
      if (mode) din = (k == 0) ? QPSK[1] : QPSK[0];
      else      din = BPSK;
      if (take) begin
        if (state_d == ST_SEARCH) begin
          sync_d = {sync_d[SYNC_LEN-2:0], din};
          if (sync_d == SYNC_PAT) begin
            state_d = ST_PAYLOAD;
            inv_d   = 1'b0;
          end else if (sync_d == ~SYNC_PAT) begin
            state_d = ST_PAYLOAD;
            inv_d   = 1'b1;
          end
        end else begin
          shr_d = {shr_d[6:0], din ^ inv_d};
          if (bitcnt_d == 3'd7) begin
            push      = 1'b1;
            push_data = shr_d;
            push_last = (bytecnt_d == LAST_IDX);
            bitcnt_d  = '0;
            if (bytecnt_d == LAST_IDX) begin
              state_d   = ST_SEARCH;
              sync_d    = '0;
              inv_d     = 1'b0;
              bytecnt_d = '0;
              shr_d     = '0;
              stop      = 1'b1;
            end else begin
              bytecnt_d = bytecnt_d + 8'd1;
            end
          end else begin
            bitcnt_d = bitcnt_d + 3'd1;
          end
        end
      end
    end
  end

  // Framer state register
  always_ff @(posedge clk or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      state_q   <= ST_SEARCH;
      sync_q    <= '0;
      inv_q     <= 1'b0;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      shr_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      inv_q     <= inv_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      shr_q     <= shr_d;
    end
  end

  // FIFO accept decision: a same-cycle pop frees the slot for a push into a full FIFO
  always_comb begin
    pop    = (cnt_q != '0) && byte_if.byte_tready;
    accept = push && ((cnt_q < FULL_CNT) || pop);
  end

  // FIFO storage, pointers, occupancy and overflow pulse
  always_ff @(posedge clk or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= {push_last, push_data};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      overflow_q <= push && !accept;
    end
  end

  // Outputs decode registered state only; data is zeroed when nothing is queued
  always_comb begin
    byte_if.byte_tvalid = (cnt_q != '0);
    byte_if.byte_tdata  = byte_if.byte_tvalid ? mem_q[rd_ptr_q][7:0] : '0;
    byte_if.byte_tlast  = byte_if.byte_tvalid ? mem_q[rd_ptr_q][8]   : 1'b0;
    locked              = (state_q == ST_PAYLOAD);
    overflow            = overflow_q;
  end

endmodule

// File: tb/tb_psk_deframer.sv
// Directed bench for psk_deframer: lock timing, inverted sync, QPSK odd alignment,
// backpressure/overflow, push/pop while full with gaps, and mid-frame reset.
module tb_psk_deframer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       BPSK = 1'b0;
  logic [1:0] QPSK = 2'b00;
  logic       vld = 1'b0;
  logic       locked;
  logic       overflow;

  psk_deframer_if bif ();

  psk_deframer dut (
    .clk          (clk),
    .rst_n_32M768 (rst_n),
    .mode         (mode),
    .BPSK         (BPSK),
    .QPSK         (QPSK),
    .vld          (vld),
    .byte_if      (bif),
    .locked       (locked),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ovf_cnt = 0;

  logic [8:0] rxq [$];
  bit         bits [$];
  logic       lk [$];
  logic       tv [$];
  logic       iv [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Record accepted bytes and overflow pulses away from the active edge
  always @(negedge clk) begin
    if (rst_n && bif.byte_tvalid && bif.byte_tready)
      rxq.push_back({bif.byte_tlast, bif.byte_tdata});
    if (rst_n && overflow) ovf_cnt++;
  end

  task automatic add_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bits.push_back(v[i]);
  endtask

  task automatic add_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bits.push_back(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      vld = 1'b0;
    end
  endtask

  // Send the queued bits; lk/tv/iv[j] hold the state seen when symbol j is driven.
  // tready is raised together with the symbol carrying bit index rdy_at.
  task automatic flush(input logic m, input int gap_max, input int rdy_at);
    int i;
    i = 0;
    lk.delete(); tv.delete(); iv.delete();
    if (m && (bits.size() % 2 != 0)) bits.push_back(1'b0);
    while (i < bits.size()) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          @(posedge clk); #2;
          vld = 1'b0;
        end
      end
      @(posedge clk); #2;
      lk.push_back(locked);
      tv.push_back(bif.byte_tvalid);
      iv.push_back(dut.inv_q);
      mode = m;
      vld  = 1'b1;
      if (i == rdy_at || (m && i + 1 == rdy_at)) bif.byte_tready = 1'b1;
      if (m) begin
        QPSK = {bits[i], bits[i+1]};
        i += 2;
      end else begin
        BPSK = bits[i];
        i += 1;
      end
    end
    @(posedge clk); #2;
    vld = 1'b0;
    bits.delete();
  endtask

  task automatic check_frame(input string tag, input logic [7:0] first, input int n);
    check({tag, "_count"}, rxq.size(), n);
    for (int j = 0; j < n && j < rxq.size(); j++)
      check($sformatf("%s_b%0d", tag, j), rxq[j], {(j == n - 1), first + 8'(j)});
    rxq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bif.byte_tready = 1'b1;
    #12;
    check("rst_tvalid", bif.byte_tvalid, 0);
    check("rst_tdata",  bif.byte_tdata,  0);
    check("rst_tlast",  bif.byte_tlast,  0);
    check("rst_locked", locked,          0);
    check("rst_ovf",    overflow,        0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(2);

    // BPSK lock and payload 01..08
    add_word(16'hEB90);
    for (int b = 1; b <= 8; b++) add_byte(8'(b));
    flush(1'b0, 0, -1);
    check("t1_lock_pre",  lk[15], 0);
    check("t1_lock_rise", lk[16], 1);
    check("t1_lock_last", lk[79], 1);
    check("t1_lock_fall", locked, 0);
    check("t1_tv_pre",    tv[23], 0);
    check("t1_tv_rise",   tv[24], 1);
    idle(4);
    check_frame("t1", 8'h01, 8);
    check("t1_ovf", ovf_cnt, 0);

    // Inverted sync: ~EB90 then ~01, ~5A, ~00 x6
    add_word(16'h146F);
    add_byte(8'hFE);
    add_byte(8'hA5);
    for (int b = 0; b < 6; b++) add_byte(8'hFF);
    flush(1'b0, 0, -1);
    check("t2_inv_set", iv[16], 1);
    check("t2_inv_pre", iv[15], 0);
    check("t2_inv_clr", dut.inv_q, 0);
    idle(4);
    check("t2_count", rxq.size(), 8);
    if (rxq.size() == 8) begin
      check("t2_b0", rxq[0], {1'b0, 8'h01});
      check("t2_b1", rxq[1], {1'b0, 8'h5A});
      check("t2_b7", rxq[7], {1'b1, 8'h00});
    end
    rxq.delete();

    // QPSK with odd alignment, then a second frame straight after
    bits.push_back(1'b0);
    add_word(16'hEB90);
    for (int b = 0; b < 8; b++) add_byte(8'hC3);
    bits.push_back(1'b1);
    add_word(16'hEB90);
    for (int b = 0; b < 8; b++) add_byte(8'h11 + 8'(b));
    flush(1'b1, 0, -1);
    idle(4);
    check("t3_count", rxq.size(), 16);
    for (int j = 0; j < 8 && j < rxq.size(); j++)
      check($sformatf("t3_f1_b%0d", j), rxq[j], {(j == 7), 8'hC3});
    for (int j = 8; j < 16 && j < rxq.size(); j++)
      check($sformatf("t3_f2_b%0d", j - 8), rxq[j], {(j == 15), 8'h11 + 8'(j - 8)});
    check("t3_ovf", ovf_cnt, 0);
    check("t3_locked", locked, 0);
    rxq.delete();

    // Backpressure: tready low for the whole QPSK frame
    bif.byte_tready = 1'b0;
    add_word(16'hEB90);
    for (int b = 0; b < 8; b++) add_byte(8'h41 + 8'(b));
    flush(1'b1, 0, -1);
    idle(3);
    check("t4_ovf", ovf_cnt, 4);
    check("t4_none", rxq.size(), 0);
    check("t4_hold_v", bif.byte_tvalid, 1);
    check("t4_hold_d", bif.byte_tdata, 8'h41);
    bif.byte_tready = 1'b1;
    idle(8);
    check("t4_count", rxq.size(), 4);
    for (int j = 0; j < 4 && j < rxq.size(); j++)
      check($sformatf("t4_b%0d", j), rxq[j], {1'b0, 8'h41 + 8'(j)});
    check("t4_empty", bif.byte_tvalid, 0);
    rxq.delete();
    ovf_cnt = 0;

    // Gaps, and a pop landing on the same edge as a push into a full FIFO
    bif.byte_tready = 1'b0;
    add_word(16'hEB90);
    for (int b = 0; b < 8; b++) add_byte(8'h31 + 8'(b));
    flush(1'b0, 2, 55);
    idle(10);
    check("t5_ovf", ovf_cnt, 0);
    check_frame("t5", 8'h31, 8);

    // Reset in the middle of a frame, then a clean frame
    bif.byte_tready = 1'b0;
    add_word(16'hEB90);
    for (int b = 0; b < 3; b++) add_byte(8'h51 + 8'(b));
    for (int b = 0; b < 4; b++) bits.push_back(1'b1);
    flush(1'b0, 0, -1);
    check("t6_pre_v", bif.byte_tvalid, 1);
    check("t6_pre_lk", locked, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", bif.byte_tvalid, 0);
    check("t6_rst_tdata",  bif.byte_tdata,  0);
    check("t6_rst_tlast",  bif.byte_tlast,  0);
    check("t6_rst_locked", locked,          0);
    check("t6_rst_ovf",    overflow,        0);
    idle(2);
    rst_n = 1'b1;
    rxq.delete();
    bif.byte_tready = 1'b1;
    add_word(16'hEB90);
    for (int b = 0; b < 8; b++) add_byte(8'h61 + 8'(b));
    flush(1'b0, 0, -1);
    idle(4);
    check_frame("t6", 8'h61, 8);
    check("t6_ovf", ovf_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
